jt12_op_sched: RTL and testbench

Slot sequencer and algorithm decoder for the JT12 FM operator pipeline. It runs the 24-slot time-division schedule (6 channels × 4 operators) and drives the operator's `s1_enters`..`s4_enters`, `zero`, `use_*` modulation selects and stage-II feedback level. It also flags carrier slots for the channel accumulator. Per-channel algorithm/feedback registers are written from the register interface and committed only at sample boundaries.

---
 rtl/jt12_op_sched_if.sv | 22 ++
 rtl/jt12_op_sched.sv | 208 ++++++++++++++++++++
 tb/tb_jt12_op_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_op_sched_if.sv
// Register-side configuration bus for the JT12 operator scheduler:
// one write strobe carrying algorithm and feedback for a single channel.
interface jt12_op_sched_if;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [2:0] cfg_alg;
  logic [2:0] cfg_fb;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_alg,
    output cfg_fb
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_alg,
    input cfg_fb
  );
endinterface

// File: rtl/jt12_op_sched.sv
// JT12 slot sequencer and algorithm decoder: walks the 24-slot operator
// schedule and decodes per-slot modulation selects from per-channel registers.
module jt12_op_sched #(
  parameter int NUM_CH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  jt12_op_sched_if.slave        cfg,
  output logic                  zero,
  output logic [4:0]            slot,
  output logic [2:0]            cur_ch,
  output logic                  s1_enters,
  output logic                  s2_enters,
  output logic                  s3_enters,
  output logic                  s4_enters,
  output logic                  use_prevprev1,
  output logic                  use_prev1,
  output logic                  use_prev2,
  output logic                  use_internal_x,
  output logic                  use_internal_y,
  output logic [2:0]            fb_II,
  output logic                  carrier
);

  localparam logic [4:0] LAST_SLOT = 5'(4 * NUM_CH - 1);
  localparam logic [2:0] LAST_CH   = 3'(NUM_CH - 1);

  // Operator groups in schedule order: S1, S3, S2, S4.
  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } grp_t;

  grp_t       grp, grp_next;
  logic [4:0] slot_next;
  logic [2:0] ch_next;

  logic [2:0] alg_act [NUM_CH];
  logic [2:0] fb_act  [NUM_CH];
  logic [2:0] alg_pen [NUM_CH];
  logic [2:0] fb_pen  [NUM_CH];
  logic [NUM_CH-1:0] pen_vld;

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] commit_edge;

  logic [2:0] alg_cur;
  logic [2:0] fb_cur;
  logic [2:0] fb_p1;

  // ---- slot counter / group sequencer (next state) ----
  always_comb begin
    slot_next = slot + 5'd1;
    ch_next   = cur_ch + 3'd1;
    grp_next  = grp;
    if (slot == LAST_SLOT) begin
      slot_next = 5'd0;
    end
    if (cur_ch == LAST_CH) begin
      ch_next = 3'd0;
      case (grp)
        GRP_S1:  grp_next = GRP_S3;
        GRP_S3:  grp_next = GRP_S2;
        GRP_S2:  grp_next = GRP_S4;
        default: grp_next = GRP_S1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot      <= 5'd0;
      cur_ch    <= 3'd0;
      grp       <= GRP_S1;
      zero      <= 1'b1;
      s1_enters <= 1'b1;
      s2_enters <= 1'b0;
      s3_enters <= 1'b0;
      s4_enters <= 1'b0;
    end else begin
      slot      <= slot_next;
      cur_ch    <= ch_next;
      grp       <= grp_next;
      zero      <= (slot_next == 5'd0);
      s1_enters <= (grp_next == GRP_S1);
      s2_enters <= (grp_next == GRP_S2);
      s3_enters <= (grp_next == GRP_S3);
      s4_enters <= (grp_next == GRP_S4);
    end
  end

  // ---- register file: pending writes land on the channel's S1 edge ----
  always_comb begin
    wr_hit      = '0;
    commit_edge = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c]      = cfg.cfg_we && (cfg.cfg_ch == 3'(c));
      commit_edge[c] = (slot_next == 5'(c));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pen_vld <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        alg_act[c] <= 3'd0;
        fb_act[c]  <= 3'd0;
        alg_pen[c] <= 3'd0;
        fb_pen[c]  <= 3'd0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (commit_edge[c]) begin
          // A write arriving on the commit edge itself wins over any pending value.
          if (wr_hit[c]) begin
            alg_act[c] <= cfg.cfg_alg;
            fb_act[c]  <= cfg.cfg_fb;
          end else if (pen_vld[c]) begin
            alg_act[c] <= alg_pen[c];
            fb_act[c]  <= fb_pen[c];
          end
          pen_vld[c] <= 1'b0;
        end else if (wr_hit[c]) begin
          alg_pen[c] <= cfg.cfg_alg;
          fb_pen[c]  <= cfg.cfg_fb;
          pen_vld[c] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    alg_cur = 3'd0;
    fb_cur  = 3'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_ch == 3'(c)) begin
        alg_cur = alg_act[c];
        fb_cur  = fb_act[c];
      end
    end
  end

  // ---- stage II: feedback level one cycle behind the slot ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_p1 <= 3'd0;
    end else begin
      fb_p1 <= fb_cur;
    end
  end

  assign fb_II = fb_p1;

  // ---- modulation-source and carrier decode for the current slot ----
  always_comb begin
    use_prevprev1  = 1'b0;
    use_prev1      = 1'b0;
    use_prev2      = 1'b0;
    use_internal_x = 1'b0;
    use_internal_y = 1'b0;
    carrier        = 1'b0;
    case (grp)
      GRP_S1: begin
        use_prevprev1 = 1'b1;
        use_prev1     = 1'b1;
        carrier       = (alg_cur == 3'd7);
      end
      GRP_S3: begin
        case (alg_cur)
          3'd0, 3'd2: use_prev2 = 1'b1;
          3'd1: begin
            use_prev2 = 1'b1;
            use_prev1 = 1'b1;
          end
          3'd5:    use_prev1 = 1'b1;
          default: ;
        endcase
        carrier = (alg_cur >= 3'd5);
      end
      GRP_S2: begin
        case (alg_cur)
          3'd0, 3'd3, 3'd4, 3'd5, 3'd6: use_internal_y = 1'b1;
          default: ;
        endcase
        carrier = (alg_cur >= 3'd4);
      end
      default: begin
        case (alg_cur)
          3'd0, 3'd1, 3'd4: use_internal_y = 1'b1;
          3'd2: begin
            use_internal_x = 1'b1;
            use_prev1      = 1'b1;
          end
          3'd3: begin
            use_prev2      = 1'b1;
            use_internal_y = 1'b1;
          end
          3'd5:    use_prev1 = 1'b1;
          default: ;
        endcase
        carrier = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_jt12_op_sched.sv
// Directed bench for jt12_op_sched: a cycle model feeds an expected-output
// scoreboard, with constant spot checks at the interesting slots.
module tb_jt12_op_sched;

  logic       clk;
  logic       rst;
  logic       zero;
  logic [4:0] slot;
  logic [2:0] cur_ch;
  logic       s1_enters, s2_enters, s3_enters, s4_enters;
  logic       use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y;
  logic [2:0] fb_II;
  logic       carrier;

  jt12_op_sched_if cfg ();

  jt12_op_sched #(.NUM_CH(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg            (cfg.slave),
    .zero           (zero),
    .slot           (slot),
    .cur_ch         (cur_ch),
    .s1_enters      (s1_enters),
    .s2_enters      (s2_enters),
    .s3_enters      (s3_enters),
    .s4_enters      (s4_enters),
    .use_prevprev1  (use_prevprev1),
    .use_prev1      (use_prev1),
    .use_prev2      (use_prev2),
    .use_internal_x (use_internal_x),
    .use_internal_y (use_internal_y),
    .fb_II          (fb_II),
    .carrier        (carrier)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] dut_vec;
  logic [5:0]  dut_dec;
  logic [3:0]  dut_en;
  assign dut_en  = {s1_enters, s2_enters, s3_enters, s4_enters};
  assign dut_dec = {use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y, carrier};
  assign dut_vec = {slot, zero, cur_ch, dut_en, dut_dec, fb_II};

  int n_checks = 0;
  int n_fail   = 0;
  int zc;
  logic [21:0] sb [$];

  // Reference state
  int         m_slot;
  logic [2:0] m_aa [6];
  logic [2:0] m_fa [6];
  logic [2:0] m_ap [6];
  logic [2:0] m_fp [6];
  bit         m_v  [6];
  logic [2:0] m_fbii;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {prevprev1, prev1, prev2, internal_x, internal_y, carrier} per group (0=S1,1=S3,2=S2,3=S4)
  function automatic logic [5:0] exp_dec(input int grp, input logic [2:0] alg);
    logic [5:0] d;
    d = 6'b000000;
    case (grp)
      0: d = {5'b11000, alg == 3'd7};
      1: begin
        case (alg)
          3'd0, 3'd2: d = 6'b001000;
          3'd1:       d = 6'b011000;
          3'd5:       d = 6'b010000;
          default:    d = 6'b000000;
        endcase
        d[0] = (alg >= 3'd5);
      end
      2: begin
        d = (alg == 3'd1 || alg == 3'd2 || alg == 3'd7) ? 6'b000000 : 6'b000010;
        d[0] = (alg >= 3'd4);
      end
      default: begin
        case (alg)
          3'd0, 3'd1, 3'd4: d = 6'b000011;
          3'd2:             d = 6'b010101;
          3'd3:             d = 6'b001011;
          3'd5:             d = 6'b010001;
          default:          d = 6'b000001;
        endcase
      end
    endcase
    return d;
  endfunction

  function automatic logic [21:0] model_out();
    int ch, grp;
    logic [3:0] en;
    ch  = m_slot % 6;
    grp = m_slot / 6;
    case (grp)
      0:       en = 4'b1000;
      1:       en = 4'b0010;
      2:       en = 4'b0100;
      default: en = 4'b0001;
    endcase
    return {5'(m_slot), (m_slot == 0), 3'(ch), en, exp_dec(grp, m_aa[ch]), m_fbii};
  endfunction

  task automatic model_reset();
    m_slot = 0;
    m_fbii = 3'd0;
    for (int c = 0; c < 6; c++) begin
      m_aa[c] = 3'd0; m_fa[c] = 3'd0; m_ap[c] = 3'd0; m_fp[c] = 3'd0; m_v[c] = 1'b0;
    end
    sb.delete();
  endtask

  task automatic model_tick(input bit we, input logic [2:0] ch, input logic [2:0] alg, input logic [2:0] fb);
    int ns;
    logic [2:0] nfb;
    nfb = m_fa[m_slot % 6];
    ns  = (m_slot + 1) % 24;
    for (int c = 0; c < 6; c++) begin
      if (ns == c) begin
        if (we && ch == 3'(c)) begin
          m_aa[c] = alg; m_fa[c] = fb;
        end else if (m_v[c]) begin
          m_aa[c] = m_ap[c]; m_fa[c] = m_fp[c];
        end
        m_v[c] = 1'b0;
      end else if (we && ch == 3'(c)) begin
        m_ap[c] = alg; m_fp[c] = fb; m_v[c] = 1'b1;
      end
    end
    m_slot = ns;
    m_fbii = nfb;
  endtask

  task automatic step(input bit we = 1'b0, input logic [2:0] ch = 3'd0,
                      input logic [2:0] alg = 3'd0, input logic [2:0] fb = 3'd0);
    logic [21:0] exp;
    cfg.cfg_we  = we;
    cfg.cfg_ch  = ch;
    cfg.cfg_alg = alg;
    cfg.cfg_fb  = fb;
    model_tick(we, ch, alg, fb);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    cfg.cfg_we = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check("cycle", 32'(dut_vec), 32'(exp));
      check("onehot", 32'($onehot(dut_en)), 32'd1);
    end
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 30 && m_slot != target; i++) step();
    check("run_to_slot", 32'(slot), 32'(target));
  endtask

  initial begin
    rst = 1'b1;
    cfg.cfg_we = 1'b0; cfg.cfg_ch = 3'd0; cfg.cfg_alg = 3'd0; cfg.cfg_fb = 3'd0;
    @(posedge clk);
    #1;
    model_reset();
    check("reset_vec", 32'(dut_vec), 32'(model_out()));
    check("reset_slot", 32'(slot), 32'd0);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_s1", 32'(dut_en), 32'b1000);
    check("reset_fb", 32'(fb_II), 32'd0);
    rst = 1'b0;

    // Free run: first edge gives slot 1, zero once per 24
    zc = 0;
    step();
    check("first_slot", 32'(slot), 32'd1);
    for (int i = 1; i < 48; i++) begin
      step();
      if (zero) zc++;
    end
    check("zero_count_48", 32'(zc), 32'd2);

    // Decode sweep on ch3
    for (int a = 0; a < 8; a++) begin
      step(1'b1, 3'd3, 3'(a), 3'(a));
      run_to(3);
      if (a == 7) check("sweep_alg7_s3", 32'(dut_dec), 32'b110001);
      run_to(9);
      if (a == 5) check("sweep_alg5_s9", 32'(dut_dec), 32'b010001);
      run_to(15);
      if (a == 0) check("sweep_alg0_s15", 32'(dut_dec), 32'b000010);
      run_to(21);
      if (a == 2) check("sweep_alg2_s21", 32'(dut_dec), 32'b010101);
    end

    // Deferred commit on ch2
    run_to(10);
    step(1'b1, 3'd2, 3'd7, 3'd0);
    run_to(14);
    check("defer_s14_old", 32'(dut_dec), 32'b000010);
    run_to(20);
    check("defer_s20_old", 32'(dut_dec), 32'b000011);
    run_to(2);
    check("defer_s2_new", 32'(dut_dec), 32'b110001);
    run_to(14);
    check("defer_s14_new", 32'(dut_dec), 32'b000001);

    // Bypass write on ch4's commit edge
    run_to(3);
    step(1'b1, 3'd4, 3'd0, 3'd5);
    check("bypass_ch", 32'(cur_ch), 32'd4);
    step();
    check("bypass_fb_s5", 32'(fb_II), 32'd5);
    run_to(4);
    run_to(5);
    check("bypass_fb_next", 32'(fb_II), 32'd5);

    // Overwrite on ch1, ignored write to ch7
    run_to(2);
    step(1'b1, 3'd1, 3'd3, 3'd0);
    step(1'b1, 3'd1, 3'd6, 3'd0);
    step(1'b1, 3'd7, 3'd5, 3'd7);
    run_to(1);
    check("ovw_s1", 32'(dut_dec), 32'b110000);
    run_to(7);
    check("ovw_s7", 32'(dut_dec), 32'b000001);
    run_to(13);
    check("ovw_s13", 32'(dut_dec), 32'b000011);
    run_to(19);
    check("ovw_s19", 32'(dut_dec), 32'b000001);

    // Reset mid-sample with a pending write on ch5
    run_to(10);
    step(1'b1, 3'd5, 3'd4, 3'd3);
    run_to(17);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_vec", 32'(dut_vec), 32'(model_out()));
    check("midrst_slot", 32'(slot), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold", 32'(dut_vec), 32'(model_out()));
    rst = 1'b0;
    step();
    check("midrst_restart", 32'(slot), 32'd1);
    run_to(11);
    check("midrst_ch5_s11", 32'(dut_dec), 32'b001000);
    run_to(23);
    check("midrst_ch5_s23", 32'(dut_dec), 32'b000011);
    step();
    check("midrst_ch5_fb", 32'(fb_II), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
